// File: rtl/seq_mul_pkg.sv
// Shared definitions for the sequential multiplier (and the companion divider):
// FSM state encoding, default operand width and the iteration-counter width helper.
package seq_mul_pkg;

  // FSM state encoding shared by the multiplier and divider.
  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_CALC = 2'd1,
    ST_DONE = 2'd2
  } state_t;

  // Default operand width in bits.
  localparam int DEFAULT_WIDTH = 4;

  // Width of a counter that must hold values 0..w.
  function automatic int cnt_width(input int w);
    return $clog2(w) + 1;
  endfunction

endpackage

// File: rtl/mul_step.sv
// One shift-and-add iteration: conditionally add the multiplicand into the
// accumulator, then shift the multiplicand left and the multiplier right.
module mul_step #(
  parameter int WIDTH = 4
) (
  input  logic [2*WIDTH-1:0] acc,
  input  logic [2*WIDTH-1:0] mcand,
  input  logic [WIDTH-1:0]   mplier,
  output logic [2*WIDTH-1:0] acc_next,
  output logic [2*WIDTH-1:0] mcand_next,
  output logic [WIDTH-1:0]   mplier_next
);

  // Add when the current multiplier LSB is set; the 2*WIDTH accumulator cannot overflow.
  always_comb begin
    acc_next    = mplier[0] ? (acc + mcand) : acc;
    mcand_next  = mcand << 1;
    mplier_next = mplier >> 1;
  end

endmodule

// File: rtl/seq_multiplier.sv
// Sequential shift-and-add unsigned multiplier with valid/ready handshakes on
// both sides. Produces a 2*WIDTH-bit product over WIDTH iterations.
// Optional feature macro: SEQ_MUL_EARLY_EXIT_EN -- when defined, the iteration
// stops as soon as the remaining multiplier bits are all zero.
module seq_multiplier
  import seq_mul_pkg::*;
#(
  parameter int WIDTH = DEFAULT_WIDTH,
  parameter int CNT_W = cnt_width(WIDTH)
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic [WIDTH-1:0]   a,
  input  logic [WIDTH-1:0]   b,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [2*WIDTH-1:0] product
);

  state_t             state_reg;
  state_t             state_next;
  logic [2*WIDTH-1:0] acc_reg;
  logic [2*WIDTH-1:0] mcand_reg;
  logic [WIDTH-1:0]   mplier_reg;
  logic [CNT_W-1:0]   count_reg;
  logic [2*WIDTH-1:0] product_reg;

  logic [2*WIDTH-1:0] step_acc;
  logic [2*WIDTH-1:0] step_mcand;
  logic [WIDTH-1:0]   step_mplier;
  logic               calc_last;
  logic               accept;

  mul_step #(.WIDTH(WIDTH)) u_step (
    .acc         (acc_reg),
    .mcand       (mcand_reg),
    .mplier      (mplier_reg),
    .acc_next    (step_acc),
    .mcand_next  (step_mcand),
    .mplier_next (step_mplier)
  );

  assign in_ready  = (state_reg == ST_IDLE) && !rst;
  assign out_valid = (state_reg == ST_DONE);
  assign product   = product_reg;
  assign accept    = in_valid && in_ready;

  // Decide whether the iteration in flight this cycle is the final one.
  always_comb begin
    calc_last = (count_reg == CNT_W'(WIDTH - 1));
`ifdef SEQ_MUL_EARLY_EXIT_EN
    // No set bits remain in the multiplier, so further iterations add nothing.
    if (step_mplier == '0) begin
      calc_last = 1'b1;
    end
`endif
  end

  // State register; reset abandons any operation in flight.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg <= ST_IDLE;
    end else begin
      state_reg <= state_next;
    end
  end

  // Next-state logic for the accept / iterate / deliver sequence.
  always_comb begin
    state_next = state_reg;
    case (state_reg)
      ST_IDLE: if (accept)    state_next = ST_CALC;
      ST_CALC: if (calc_last) state_next = ST_DONE;
      ST_DONE: if (out_ready) state_next = ST_IDLE;
      default:                state_next = ST_IDLE;
    endcase
  end

  // Datapath: load operands on accept, iterate in CALC, capture the final product.
  always_ff @(posedge clk) begin
    if (rst) begin
      acc_reg     <= '0;
      mcand_reg   <= '0;
      mplier_reg  <= '0;
      count_reg   <= '0;
      product_reg <= '0;
    end else begin
      case (state_reg)
        ST_IDLE: begin
          if (accept) begin
            acc_reg    <= '0;
            mcand_reg  <= {{WIDTH{1'b0}}, a};
            mplier_reg <= b;
            count_reg  <= '0;
          end
        end
        ST_CALC: begin
          acc_reg    <= step_acc;
          mcand_reg  <= step_mcand;
          mplier_reg <= step_mplier;
          count_reg  <= count_reg + CNT_W'(1);
          if (calc_last) begin
            product_reg <= step_acc;
          end
        end
        default: ;
      endcase
    end
  end

endmodule
